// File: rtl/exc_pkg.sv
// Shared constants for the WB-stage exception commit sequencer: cause bit
// positions, ecode/esubcode values and the sequencer state encoding.
package exc_pkg;

  localparam int EXC_ADEF = 0;
  localparam int EXC_ALE  = 1;
  localparam int EXC_SYS  = 2;
  localparam int EXC_BRK  = 3;
  localparam int EXC_INE  = 4;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam logic [8:0] ESUBCODE_NONE = 9'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAP  = 2'd1,
    ST_ERTN  = 2'd2,
    ST_DRAIN = 2'd3
  } exc_state_e;

  // Cause flags beyond the architected five fold onto INE.
  function automatic logic [5:0] cause_ecode(input int idx);
    case (idx)
      EXC_ADEF: cause_ecode = ECODE_ADEF;
      EXC_ALE:  cause_ecode = ECODE_ALE;
      EXC_SYS:  cause_ecode = ECODE_SYS;
      EXC_BRK:  cause_ecode = ECODE_BRK;
      default:  cause_ecode = ECODE_INE;
    endcase
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder over synchronous cause flags; bit 0 wins.
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int NUM_EXC = 5
) (
  input  logic [NUM_EXC-1:0] exc_vec,
  output logic               hit,
  output logic [5:0]         ecode
);

  // Scan from the lowest-priority bit upward so the highest-priority hit is written last.
  always_comb begin
    hit   = 1'b0;
    ecode = 6'h00;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (exc_vec[i]) begin
        hit   = 1'b1;
        ecode = cause_ecode(i);
      end
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// WB-stage trap/ertn commit sequencer driving the CSR port, flush and redirect.
// Optional bad-address capture is enabled by defining EXC_BADV_EN.
module exc_commit_ctrl
  import exc_pkg::*;
#(
  parameter int NUM_EXC      = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_valid,
  output logic               wb_ready,
  input  logic [31:0]        wb_pc,
  input  logic [NUM_EXC-1:0] wb_exc_vec,
  input  logic               wb_is_ertn,
  input  logic               wb_csr_we,
  input  logic [13:0]        wb_csr_num,
  input  logic [31:0]        wb_csr_wmask,
  input  logic [31:0]        wb_csr_wvalue,
  input  logic               has_int,
  input  logic [31:0]        ex_entry,
  input  logic [31:0]        ertn_pc,
  output logic               csr_we,
  output logic [13:0]        csr_num,
  output logic [31:0]        csr_wmask,
  output logic [31:0]        csr_wvalue,
  output logic               wb_ex,
  output logic [5:0]         wb_ecode,
  output logic [8:0]         wb_esubcode,
  output logic [31:0]        wb_epc,
  output logic               ertn_flush,
  output logic               flush_o,
  output logic               redirect_valid,
`ifdef EXC_BADV_EN
  input  logic [31:0]        wb_badv,
  output logic               csr_badv_we,
  output logic [31:0]        csr_badv,
`endif
  output logic [31:0]        redirect_pc
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  exc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exc_hit;
  logic [5:0]       exc_ecode;
  logic             commit;

  exc_prio_enc #(.NUM_EXC(NUM_EXC)) u_prio (
    .exc_vec (wb_exc_vec),
    .hit     (exc_hit),
    .ecode   (exc_ecode)
  );

  assign commit = (state_q == ST_IDLE) && wb_valid && !reset;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wb_ready       = 1'b0;
    csr_we         = 1'b0;
    csr_num        = '0;
    csr_wmask      = '0;
    csr_wvalue     = '0;
    wb_ex          = 1'b0;
    wb_ecode       = '0;
    wb_esubcode    = '0;
    wb_epc         = '0;
    ertn_flush     = 1'b0;
    flush_o        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
`ifdef EXC_BADV_EN
    csr_badv_we    = 1'b0;
    csr_badv       = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        wb_ready = 1'b1;
        if (commit) begin
          if (has_int || exc_hit) begin
            // A pending cause outranks ertn and suppresses the CSR write.
            wb_ex       = 1'b1;
            wb_ecode    = has_int ? ECODE_INT : exc_ecode;
            wb_esubcode = ESUBCODE_NONE;
            wb_epc      = wb_pc;
            state_d     = ST_TRAP;
`ifdef EXC_BADV_EN
            if (!has_int && wb_exc_vec[EXC_ADEF]) begin
              csr_badv_we = 1'b1;
              csr_badv    = wb_pc;
            end else if (!has_int && wb_exc_vec[EXC_ALE]) begin
              csr_badv_we = 1'b1;
              csr_badv    = wb_badv;
            end
`endif
          end else if (wb_is_ertn) begin
            ertn_flush = 1'b1;
            state_d    = ST_ERTN;
          end else if (wb_csr_we) begin
            csr_we     = 1'b1;
            csr_num    = wb_csr_num;
            csr_wmask  = wb_csr_wmask;
            csr_wvalue = wb_csr_wvalue;
          end
        end
      end
      ST_TRAP, ST_ERTN: begin
        // ex_entry/ertn_pc are read here so the CSR update from the commit cycle is visible.
        flush_o        = 1'b1;
        redirect_valid = !reset;
        redirect_pc    = (state_q == ST_TRAP) ? ex_entry : ertn_pc;
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        flush_o = 1'b1;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Randomised bench for exc_commit_ctrl against a timeline model of commit/flush/redirect.
module tb_exc_commit_ctrl;
  localparam int NUM_EXC = 5;
  localparam int FC      = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               wb_valid;
  logic               wb_ready;
  logic [31:0]        wb_pc;
  logic [NUM_EXC-1:0] wb_exc_vec;
  logic               wb_is_ertn;
  logic               wb_csr_we;
  logic [13:0]        wb_csr_num;
  logic [31:0]        wb_csr_wmask;
  logic [31:0]        wb_csr_wvalue;
  logic               has_int;
  logic [31:0]        ex_entry;
  logic [31:0]        ertn_pc;
  logic               csr_we;
  logic [13:0]        csr_num;
  logic [31:0]        csr_wmask;
  logic [31:0]        csr_wvalue;
  logic               wb_ex;
  logic [5:0]         wb_ecode;
  logic [8:0]         wb_esubcode;
  logic [31:0]        wb_epc;
  logic               ertn_flush;
  logic               flush_o;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
`ifdef EXC_BADV_EN
  logic [31:0]        wb_badv;
  logic               csr_badv_we;
  logic [31:0]        csr_badv;
`endif

  exc_commit_ctrl #(.NUM_EXC(NUM_EXC), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_pc          (wb_pc),
    .wb_exc_vec     (wb_exc_vec),
    .wb_is_ertn     (wb_is_ertn),
    .wb_csr_we      (wb_csr_we),
    .wb_csr_num     (wb_csr_num),
    .wb_csr_wmask   (wb_csr_wmask),
    .wb_csr_wvalue  (wb_csr_wvalue),
    .has_int        (has_int),
    .ex_entry       (ex_entry),
    .ertn_pc        (ertn_pc),
    .csr_we         (csr_we),
    .csr_num        (csr_num),
    .csr_wmask      (csr_wmask),
    .csr_wvalue     (csr_wvalue),
    .wb_ex          (wb_ex),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .wb_epc         (wb_epc),
    .ertn_flush     (ertn_flush),
    .flush_o        (flush_o),
    .redirect_valid (redirect_valid),
`ifdef EXC_BADV_EN
    .wb_badv        (wb_badv),
    .csr_badv_we    (csr_badv_we),
    .csr_badv       (csr_badv),
`endif
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: k = -1 when able to retire, else cycles elapsed since the commit (1..FC).
  int k = -1;
  bit kind_trap = 1'b0;
  bit e_trap, e_ertn;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] ref_ecode(input logic hi, input logic [NUM_EXC-1:0] v);
    logic [5:0] codes [5] = '{6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D};
    if (hi) return 6'h00;
    for (int i = 0; i < NUM_EXC; i++)
      if (v[i]) return codes[i];
    return 6'h00;
  endfunction

  task automatic check_all();
    bit busy, e_csr, e_redir;
    busy    = (k >= 1);
    e_trap  = !busy && !reset && wb_valid && (has_int || (|wb_exc_vec));
    e_ertn  = !busy && !reset && wb_valid && !e_trap && wb_is_ertn;
    e_csr   = !busy && !reset && wb_valid && !e_trap && !e_ertn && wb_csr_we;
    e_redir = busy && (k == 1) && !reset;
    chk("wb_ready", 32'(wb_ready), 32'(!busy));
    chk("wb_ex", 32'(wb_ex), 32'(e_trap));
    chk("ertn_flush", 32'(ertn_flush), 32'(e_ertn));
    chk("csr_we", 32'(csr_we), 32'(e_csr));
    chk("flush_o", 32'(flush_o), 32'(busy));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_redir));
    if (e_trap) begin
      chk("wb_ecode", 32'(wb_ecode), 32'(ref_ecode(has_int, wb_exc_vec)));
      chk("wb_esubcode", 32'(wb_esubcode), 32'd0);
      chk("wb_epc", wb_epc, wb_pc);
    end
    if (e_csr) begin
      chk("csr_num", 32'(csr_num), 32'(wb_csr_num));
      chk("csr_wmask", csr_wmask, wb_csr_wmask);
      chk("csr_wvalue", csr_wvalue, wb_csr_wvalue);
    end
    if (e_redir) chk("redirect_pc", redirect_pc, kind_trap ? ex_entry : ertn_pc);
`ifdef EXC_BADV_EN
    begin
      bit e_bw;
      e_bw = e_trap && !has_int && (wb_exc_vec[0] || wb_exc_vec[1]);
      chk("csr_badv_we", 32'(csr_badv_we), 32'(e_bw));
      if (e_bw) chk("csr_badv", csr_badv, wb_exc_vec[0] ? wb_pc : wb_badv);
    end
`endif
  endtask

  task automatic advance();
    if (reset) k = -1;
    else if (k == -1) begin
      if (e_trap)      begin k = 1; kind_trap = 1'b1; end
      else if (e_ertn) begin k = 1; kind_trap = 1'b0; end
    end else k = (k >= FC) ? -1 : k + 1;
  endtask

  task automatic tick_pre();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick_post();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic quiet();
    reset = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_exc_vec = '0; wb_is_ertn = 1'b0;
    wb_csr_we = 1'b0; wb_csr_num = '0; wb_csr_wmask = '0; wb_csr_wvalue = '0;
    has_int = 1'b0; ex_entry = 32'h1c008000; ertn_pc = 32'h1c000200;
`ifdef EXC_BADV_EN
    wb_badv = '0;
`endif
  endtask

  task automatic rand_inputs();
    reset         = ($urandom_range(0, 39) == 0);
    wb_valid      = ($urandom_range(0, 9) < 6);
    wb_pc         = $urandom;
    for (int i = 0; i < NUM_EXC; i++) wb_exc_vec[i] = ($urandom_range(0, 9) == 0);
    wb_is_ertn    = ($urandom_range(0, 5) == 0);
    wb_csr_we     = ($urandom_range(0, 2) == 0);
    wb_csr_num    = 14'($urandom);
    wb_csr_wmask  = $urandom;
    wb_csr_wvalue = $urandom;
    has_int       = ($urandom_range(0, 9) == 0);
    ex_entry      = $urandom;
    ertn_pc       = $urandom;
`ifdef EXC_BADV_EN
    wb_badv       = $urandom;
`endif
  endtask

  initial begin
    int flush_cnt, low_cnt;
    quiet();
    reset = 1'b1;
    @(posedge clk); #1;
    tick_pre(); tick_post();
    tick_pre();
    chk("reset_ready", 32'(wb_ready), 32'd1);
    chk("reset_flush", 32'(flush_o), 32'd0);
    tick_post();
    reset = 1'b0;
    tick_pre(); tick_post();

    // SYS alone
    wb_valid = 1'b1; wb_exc_vec = 5'b00100; wb_pc = 32'h1c000100;
    tick_pre();
    chk("sys_ex", 32'(wb_ex), 32'd1);
    chk("sys_ecode", 32'(wb_ecode), 32'h0B);
    chk("sys_epc", wb_epc, 32'h1c000100);
    tick_post();
    wb_valid = 1'b0; wb_exc_vec = '0;
    tick_pre();
    chk("sys_redir", 32'(redirect_valid), 32'd1);
    chk("sys_redir_pc", redirect_pc, 32'h1c008000);
    tick_post();
    while (k != -1) begin tick_pre(); tick_post(); end

    // ADEF+INE, with and without interrupt; CSR write must be suppressed
    for (int h = 1; h >= 0; h--) begin
      wb_valid = 1'b1; wb_exc_vec = 5'b10001; has_int = h[0]; wb_csr_we = 1'b1;
      tick_pre();
      chk("adef_ine_ecode", 32'(wb_ecode), h ? 32'h00 : 32'h08);
      chk("adef_ine_csr_we", 32'(csr_we), 32'd0);
      tick_post();
      quiet();
      while (k != -1) begin tick_pre(); tick_post(); end
    end

    // ertn: flush length and retire stall
    wb_valid = 1'b1; wb_is_ertn = 1'b1;
    tick_pre();
    chk("ertn_pulse", 32'(ertn_flush), 32'd1);
    tick_post();
    quiet();
    flush_cnt = 0; low_cnt = 0;
    for (int c = 0; c < 10 && !wb_ready; c++) begin
      tick_pre();
      if (redirect_valid) chk("ertn_redir_pc", redirect_pc, 32'h1c000200);
      if (flush_o) flush_cnt++;
      if (!wb_ready) low_cnt++;
      tick_post();
    end
    chk("ertn_flush_cycles", 32'(flush_cnt), 32'd2);
    chk("ertn_ready_low", 32'(low_cnt), 32'd2);

    // csrwr with no cause
    wb_valid = 1'b1; wb_csr_we = 1'b1; wb_csr_num = 14'h30; wb_csr_wmask = 32'hFFFFFFFF;
    wb_csr_wvalue = 32'hA5A5_0001;
    tick_pre();
    chk("csrwr_we", 32'(csr_we), 32'd1);
    chk("csrwr_num", 32'(csr_num), 32'h30);
    chk("csrwr_flush", 32'(flush_o), 32'd0);
    tick_post();
    tick_pre();
    chk("csrwr_idle", 32'(wb_ready), 32'd1);
    tick_post();
    quiet();

    // reset during drain
    wb_valid = 1'b1; wb_exc_vec = 5'b01000;
    tick_pre(); tick_post();
    quiet();
    tick_pre(); tick_post();
    reset = 1'b1;
    tick_pre(); tick_post();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick_pre();
      chk("rst_drain_flush", 32'(flush_o), 32'd0);
      chk("rst_drain_redir", 32'(redirect_valid), 32'd0);
      tick_post();
    end

`ifdef EXC_BADV_EN
    wb_valid = 1'b1; wb_exc_vec = 5'b00010; wb_badv = 32'h1234;
    tick_pre();
    chk("badv_we", 32'(csr_badv_we), 32'd1);
    chk("badv_val", csr_badv, 32'h1234);
    chk("badv_ex", 32'(wb_ex), 32'd1);
    tick_post();
    quiet();
    while (k != -1) begin tick_pre(); tick_post(); end
`endif

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      tick_pre();
      tick_post();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
